pu_rom_fetch: RTL and testbench
===============================

Name: pu_rom_fetch

Overview:
- Parametrised successor to the processor-unit instruction ROM read port.
- Takes word fetch requests from the fetch stage over a req/ready/valid handshake.
- Drives LANES independent byte-wide ROM address lanes, waits a configurable ROM latency, then assembles one little-endian word.
- Adds misalignment and range fault reporting, flush/abort, and an optional sequential prefetch buffer.

Parameters:
- ADDR_W, 11, ROM byte-address width per lane.
- LANES, 4, bytes per fetched word. Legal values: 2, 4, 8.
- ROM_LAT, 1, cycles from rom_addr_out/rom_en_out to valid rom_data_in. Legal range: 1..7.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_in  in  1  fetch request.
- addr_in  in  32  byte address of requested word.
- flush_in  in  1  abort in-flight fetch and invalidate the prefetch buffer.
- ready_out  out  1  request can be accepted this cycle.
- valid_out  out  1  one-cycle pulse: data_out/err_out are valid.
- data_out  out  8*LANES  fetched word; lane i occupies bits [8i+7:8i].
- err_out  out  1  fault flag, qualified by valid_out.
- rom_en_out  out  1  ROM read enable.
- rom_addr_out  out  LANES*ADDR_W  flattened lane addresses; lane i occupies bits [ADDR_W*i+ADDR_W-1:ADDR_W*i].
- rom_data_in  in  8*LANES  flattened lane read data.

Behaviour:
- Reset values: ready_out=0 during reset and 1 in the first cycle after reset; valid_out=0, err_out=0, data_out=0, rom_en_out=0, rom_addr_out=0; FSM=IDLE; wait counter=0; prefetch buffer invalid.
- FSM states: IDLE, WAIT, DONE, FAULT.
- ready_out=1 in IDLE and DONE, 0 otherwise.
- Accept condition: req_in & ready_out & !flush_in.
- On accept, register addr_in.
  - Fault check, using LB=log2(LANES): fault if addr_in[LB-1:0]!=0 (misaligned) or addr_in[31:ADDR_W]!=0 (out of range). On fault go to FAULT; the ROM is not enabled.
  - Otherwise go to WAIT. Registered lane i address = addr_in[ADDR_W-1:0]+i. Alignment guarantees no wrap. rom_en_out=1 for exactly ROM_LAT cycles; the counter loads ROM_LAT-1 and counts down.
- WAIT -> DONE when the counter reaches 0 with rom_en_out high. On that edge capture data_out={lane LANES-1,...,lane 0}.
- DONE: valid_out=1, err_out=0. Next state: WAIT or FAULT if a new request is accepted that cycle, else IDLE.
- FAULT: valid_out=1, err_out=1, data_out=0. Always returns to IDLE.
- Latency: good fetch valid ROM_LAT+1 cycles after the accept edge. Fault valid 1 cycle after the accept edge.
- data_out holds its last value until the next capture or fault.
- flush_in in WAIT: drop rom_en_out next edge, return to IDLE, no valid_out.
- flush_in in DONE/FAULT: valid_out still pulses that cycle, no request is accepted, next state is IDLE.
- flush_in in IDLE: no effect other than blocking accept.
- Any request during reset is discarded. Reset mid-fetch gives the reset values at the next edge and no valid_out.
- Simultaneous req_in and flush_in: flush wins; the request is not accepted and the requester must hold req_in.

Optional Feature:
- Macro: PU_ROM_PREFETCH_EN.
- Defined:
  - After a good fetch at A, if A+LANES is in range and the FSM sits in IDLE, the block issues a background ROM read of A+LANES into a one-word buffer tagged with that address. This read takes ROM_LAT cycles; ready_out stays 1 throughout.
  - A request whose address equals the tag while the buffer is valid is a hit: valid_out fires 1 cycle after accept with the buffered word, and the next prefetch is launched.
  - A request during an in-flight prefetch to a different address cancels the prefetch and starts the demand fetch that cycle.
  - A request matching the in-flight prefetch address completes when the prefetch lands.
  - flush_in or rst invalidates the buffer.
- Undefined: no buffer, no background reads; every good fetch takes ROM_LAT+1 cycles.

Test Plan:
- Config LANES=4, ROM_LAT=1; ROM byte k holds k[7:0].
- Request 0x10 -> rom_addr_out lanes 0x010..0x013 with rom_en_out=1 for one cycle; valid_out 2 cycles after accept; data_out=0x13121110, err_out=0.
- Request 0x11 -> valid_out+err_out 1 cycle later, data_out=0, rom_en_out never high. Request 0x800 -> same fault response.
- Config ROM_LAT=3: request 0x20, flush_in 2 cycles later -> rom_en_out drops, no valid_out, ready_out=1 the next cycle.
- Back-to-back: request 0x00 held, then 0x04 accepted in the DONE cycle -> valids 2 cycles apart, data 0x03020100 then 0x07060504.
- rst asserted mid-WAIT -> all outputs 0 the next cycle; no valid_out after release.
- PU_ROM_PREFETCH_EN: fetch 0x10, idle 3 cycles, request 0x14 -> valid_out 1 cycle after accept, data_out=0x17161514. After flush, request 0x14 -> ROM_LAT+1 latency.

Source files
------------

// File: rtl/pu_rom_fetch.sv
// pu_rom_fetch: processor-unit instruction ROM read port.
// Accepts word fetches on a req/ready handshake, drives LANES byte-wide ROM
// address lanes for ROM_LAT cycles and returns one little-endian word as a
// one-cycle valid/err pulse. Misaligned or out-of-range requests fault
// without enabling the ROM. flush_in aborts an in-flight fetch.
// Optional sequential prefetch buffer: define PU_ROM_PREFETCH_EN.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_in, addr_in           fetch request and byte address
//   flush_in                  abort fetch, invalidate prefetch buffer
//   ready_out                 request can be accepted this cycle
//   valid_out, data_out, err_out   result pulse, word, fault flag
//   rom_en_out, rom_addr_out  ROM enable and flattened lane addresses
//   rom_data_in               flattened lane read data
module pu_rom_fetch #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_in,
  input  logic [31:0]             addr_in,
  input  logic                    flush_in,
  output logic                    ready_out,
  output logic                    valid_out,
  output logic [8*LANES-1:0]      data_out,
  output logic                    err_out,
  output logic                    rom_en_out,
  output logic [LANES*ADDR_W-1:0] rom_addr_out,
  input  logic [8*LANES-1:0]      rom_data_in
);

  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned RW = LANES * ADDR_W;
  localparam int unsigned LB = $clog2(LANES);
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept_c, fault_c, go_c, capture_c;
  // prefetch hooks; tied off when the buffer is not built
  logic          hit_c, join_c, join_now_c, launch_c, pf_en_c;
  logic [CW-1:0] join_cnt_c;
  logic [DW-1:0] pf_word_c;
  logic [ADDR_W-1:0] launch_addr_c;

  // lane i reads base+i; alignment keeps all lanes inside one word
  function automatic logic [RW-1:0] lanes_of(input logic [ADDR_W-1:0] base);
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*ADDR_W +: ADDR_W] = base + ADDR_W'(i);
    return v;
  endfunction

  assign accept_c  = req_in & ready_out & ~flush_in;
  assign fault_c   = (|addr_in[LB-1:0]) | (|(addr_in >> ADDR_W));
  assign go_c      = accept_c & ~fault_c;
  assign capture_c = (state == S_WAIT) && (cnt == CW'(0)) && !flush_in;

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          if (fault_c)                  state_nx = S_FAULT;
          else if (hit_c || join_now_c) state_nx = S_DONE;
          else                          state_nx = S_WAIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_in)              state_nx = S_IDLE;
        else if (cnt == CW'(0))    state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ready_out    <= 1'b0;
      valid_out    <= 1'b0;
      err_out      <= 1'b0;
      data_out     <= '0;
      rom_en_out   <= 1'b0;
      rom_addr_out <= '0;
    end else begin
      state      <= state_nx;
      ready_out  <= (state_nx == S_IDLE) || (state_nx == S_DONE);
      valid_out  <= (state_nx == S_DONE) || (state_nx == S_FAULT);
      err_out    <= (state_nx == S_FAULT);
      rom_en_out <= (state_nx == S_WAIT) || pf_en_c;

      if ((state == S_WAIT) && (cnt != CW'(0))) cnt <= cnt - CW'(1);

      if (go_c) begin
        // joining an in-flight prefetch keeps its lanes and remaining time
        if (join_c) begin
          cnt <= join_cnt_c;
        end else begin
          cnt          <= CW'(ROM_LAT - 1);
          rom_addr_out <= lanes_of(addr_in[ADDR_W-1:0]);
        end
      end else if (launch_c) begin
        rom_addr_out <= lanes_of(launch_addr_c);
      end

      if (capture_c)                         data_out <= rom_data_in;
      else if (accept_c && fault_c)          data_out <= '0;
      else if (go_c && (hit_c || join_now_c)) data_out <= pf_word_c;
    end
  end

`ifdef PU_ROM_PREFETCH_EN
  logic              pf_valid, pf_busy, pf_pend;
  logic [ADDR_W-1:0] pf_tag, pf_addr, pf_next, req_addr;
  logic [DW-1:0]     pf_data;
  logic [CW-1:0]     pf_cnt;
  logic [ADDR_W:0]   next_sum_c;

  assign hit_c      = pf_valid && (pf_tag == addr_in[ADDR_W-1:0]);
  assign join_c     = !hit_c && pf_busy && (pf_addr == addr_in[ADDR_W-1:0]);
  assign join_now_c = join_c && (pf_cnt == CW'(0));
  assign join_cnt_c = pf_cnt - CW'(1);
  assign launch_c   = (state == S_IDLE) && pf_pend && !pf_busy && !accept_c &&
                      !flush_in && !(pf_valid && (pf_tag == pf_next));
  assign pf_en_c    = launch_c ||
                      (pf_busy && (pf_cnt != CW'(0)) && !accept_c && !flush_in);
  assign launch_addr_c = pf_next;
  assign pf_word_c  = hit_c ? pf_data : rom_data_in;
  // carry out means the next word is beyond the ROM
  assign next_sum_c = {1'b0, req_addr} + (ADDR_W+1)'(LANES);

  // background read of the next sequential word into a one-word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_valid <= 1'b0;
      pf_busy  <= 1'b0;
      pf_pend  <= 1'b0;
      pf_tag   <= '0;
      pf_addr  <= '0;
      pf_next  <= '0;
      pf_data  <= '0;
      pf_cnt   <= '0;
      req_addr <= '0;
    end else begin
      if (go_c) req_addr <= addr_in[ADDR_W-1:0];
      if (flush_in) begin
        pf_valid <= 1'b0;
        pf_busy  <= 1'b0;
        pf_pend  <= 1'b0;
      end else begin
        if (state == S_DONE) begin
          pf_pend <= !next_sum_c[ADDR_W];
          pf_next <= next_sum_c[ADDR_W-1:0];
        end else if (launch_c) begin
          pf_pend <= 1'b0;
        end
        if (launch_c) begin
          pf_busy <= 1'b1;
          pf_addr <= pf_next;
          pf_cnt  <= CW'(ROM_LAT - 1);
        end else if (pf_busy) begin
          if (accept_c) begin
            pf_busy <= 1'b0;
          end else if (pf_cnt == CW'(0)) begin
            pf_busy  <= 1'b0;
            pf_valid <= 1'b1;
            pf_tag   <= pf_addr;
            pf_data  <= rom_data_in;
          end else begin
            pf_cnt <= pf_cnt - CW'(1);
          end
        end
      end
    end
  end
`else
  assign hit_c         = 1'b0;
  assign join_c        = 1'b0;
  assign join_now_c    = 1'b0;
  assign launch_c      = 1'b0;
  assign pf_en_c       = 1'b0;
  assign join_cnt_c    = '0;
  assign pf_word_c     = '0;
  assign launch_addr_c = '0;
`endif

endmodule

// File: tb/tb_pu_rom_fetch.sv
// Bench for pu_rom_fetch: vector table, directed corner sequences and a
// randomized scoreboard run. Two instances: ROM_LAT=1 (u0) and ROM_LAT=3 (u3).
module tb_pu_rom_fetch;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DW     = 8 * LANES;
  localparam int unsigned RW     = LANES * ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic req0, flush0, ready0, valid0, err0, en0;
  logic [31:0] addr0;
  logic [DW-1:0] data0, rdata0;
  logic [RW-1:0] raddr0;
  logic req3, flush3, ready3, valid3, err3, en3;
  logic [31:0] addr3;
  logic [DW-1:0] data3, rdata3;
  logic [RW-1:0] raddr3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pu_rom_fetch #(.ADDR_W(ADDR_W), .LANES(LANES), .ROM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .req_in(req0), .addr_in(addr0), .flush_in(flush0),
    .ready_out(ready0), .valid_out(valid0), .data_out(data0), .err_out(err0),
    .rom_en_out(en0), .rom_addr_out(raddr0), .rom_data_in(rdata0));

  pu_rom_fetch #(.ADDR_W(ADDR_W), .LANES(LANES), .ROM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_in(req3), .addr_in(addr3), .flush_in(flush3),
    .ready_out(ready3), .valid_out(valid3), .data_out(data3), .err_out(err3),
    .rom_en_out(en3), .rom_addr_out(raddr3), .rom_data_in(rdata3));

  // ROM contents: byte k holds k[7:0]; garbage while not enabled
  function automatic logic [DW-1:0] rom_word(input logic [RW-1:0] ra);
    logic [DW-1:0] w;
    for (int i = 0; i < LANES; i++) w[8*i +: 8] = ra[ADDR_W*i +: 8];
    return w;
  endfunction
  assign rdata0 = en0 ? rom_word(raddr0) : DW'(32'hA5A5A5A5);
  assign rdata3 = en3 ? rom_word(raddr3) : DW'(32'hA5A5A5A5);

  function automatic logic [DW-1:0] exp_word(input logic [31:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < LANES; i++) w[8*i +: 8] = 8'(a + 32'(i));
    return w;
  endfunction

  function automatic logic [RW-1:0] exp_lanes(input logic [31:0] a);
    logic [RW-1:0] v;
    for (int i = 0; i < LANES; i++) v[ADDR_W*i +: ADDR_W] = ADDR_W'(a + 32'(i));
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one request on u0; lat counts cycles after the accept edge, 0 if no valid
  task automatic fetch1(input logic [31:0] a, output int lat, output logic [DW-1:0] d,
                        output logic e, output int en_cyc, output logic [RW-1:0] ra);
    req0 = 1'b1; addr0 = a;
    tick();
    req0 = 1'b0;
    lat = 0; en_cyc = 0; d = '0; e = 1'b0; ra = '0;
    for (int k = 1; k <= 16; k++) begin
      if (en0) begin en_cyc++; ra = raddr0; end
      if (valid0) begin lat = k; d = data0; e = err0; break; end
      tick();
    end
  endtask

  task automatic fetch3(input logic [31:0] a, output int lat, output logic [DW-1:0] d,
                        output int en_cyc);
    req3 = 1'b1; addr3 = a;
    tick();
    req3 = 1'b0;
    lat = 0; en_cyc = 0; d = '0;
    for (int k = 1; k <= 16; k++) begin
      if (en3) en_cyc++;
      if (valid3) begin lat = k; d = data3; break; end
      tick();
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
    int          lat;
    int          en_cyc;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, enc, seen;
    logic [DW-1:0] d;
    logic e, m_err, do_flush;
    logic [RW-1:0] ra;
    logic [31:0] a, prev_a, m_data;
    int cat;

    vt[0] = '{32'h0000_0010, 1'b0, 32'h1312_1110, 2, 1};
    vt[1] = '{32'h0000_0011, 1'b1, 32'h0000_0000, 1, 0};
    vt[2] = '{32'h0000_0800, 1'b1, 32'h0000_0000, 1, 0};
    vt[3] = '{32'h0000_07FC, 1'b0, 32'hFFFE_FDFC, 2, 1};
    vt[4] = '{32'h0000_0002, 1'b1, 32'h0000_0000, 1, 0};
    vt[5] = '{32'hFFFF_FFF0, 1'b1, 32'h0000_0000, 1, 0};
    vt[6] = '{32'h0000_0000, 1'b0, 32'h0302_0100, 2, 1};
    vt[7] = '{32'h0000_0404, 1'b0, 32'h0706_0504, 2, 1};

    rst = 1'b1;
    req0 = 1'b0; flush0 = 1'b0; addr0 = '0;
    req3 = 1'b0; flush3 = 1'b0; addr3 = '0;
    req0 = 1'b1; addr0 = 32'h40;  // request during reset must be discarded
    tick(); tick(); tick();
    check("rst_ready", 64'(ready0), 64'd0);
    check("rst_valid", 64'(valid0), 64'd0);
    check("rst_err", 64'(err0), 64'd0);
    check("rst_en", 64'(en0), 64'd0);
    check("rst_data", 64'(data0), 64'd0);
    check("rst_raddr", 64'(raddr0), 64'd0);
    check("rst_ready3", 64'(ready3), 64'd0);
    req0 = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(ready0), 64'd1);
    check("post_rst_ready3", 64'(ready3), 64'd1);
    check("post_rst_valid", 64'(valid0), 64'd0);

    // vector table
    foreach (vt[i]) begin
      check("vec_ready", 64'(ready0), 64'd1);
      fetch1(vt[i].addr, lat, d, e, enc, ra);
      check("vec_lat", 64'(lat), 64'(vt[i].lat));
      check("vec_data", 64'(d), 64'(vt[i].data));
      check("vec_err", 64'(e), 64'(vt[i].err));
      check("vec_en_cycles", 64'(enc), 64'(vt[i].en_cyc));
      if (!vt[i].err) check("vec_rom_addr", 64'(ra), 64'(exp_lanes(vt[i].addr)));
      tick();
    end

    // back-to-back: 0x00 held, 0x04 accepted in the DONE cycle
    req0 = 1'b1; addr0 = 32'h0;
    tick();
    check("b2b_wait_ready", 64'(ready0), 64'd0);
    tick();
    check("b2b_valid1", 64'(valid0), 64'd1);
    check("b2b_data1", 64'(data0), 64'h0302_0100);
    addr0 = 32'h4;
    tick();
    req0 = 1'b0;
    check("b2b_gap", 64'(valid0), 64'd0);
    tick();
    check("b2b_valid2", 64'(valid0), 64'd1);
    check("b2b_data2", 64'(data0), 64'h0706_0504);
    tick();

    // flush in DONE: valid still seen, concurrent request not accepted
    req0 = 1'b1; addr0 = 32'h8;
    tick();
    req0 = 1'b0;
    tick();
    check("fdone_valid", 64'(valid0), 64'd1);
    flush0 = 1'b1; req0 = 1'b1; addr0 = 32'hC;
    tick();
    check("fdone_no_accept_en", 64'(en0), 64'd0);
    check("fdone_ready", 64'(ready0), 64'd1);
    check("fdone_valid_off", 64'(valid0), 64'd0);
    flush0 = 1'b0;
    tick();
    check("fdone_held_accept", 64'(en0), 64'd1);
    req0 = 1'b0;
    tick();
    check("fdone_held_data", 64'(data0), 64'h0F0E_0D0C);
    tick();

    // flush and request together in IDLE: flush wins
    req0 = 1'b1; flush0 = 1'b1; addr0 = 32'h40;
    tick();
    req0 = 1'b0; flush0 = 1'b0;
    check("fidle_en", 64'(en0), 64'd0);
    check("fidle_ready", 64'(ready0), 64'd1);
    tick();
    check("fidle_valid", 64'(valid0), 64'd0);

    // ROM_LAT=3: flush two cycles after accept
    req3 = 1'b1; addr3 = 32'h20;
    tick();
    req3 = 1'b0;
    check("l3_en_c1", 64'(en3), 64'd1);
    check("l3_ready_c1", 64'(ready3), 64'd0);
    tick();
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    check("l3_flush_en", 64'(en3), 64'd0);
    check("l3_flush_ready", 64'(ready3), 64'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid3) seen++;
      tick();
    end
    check("l3_flush_no_valid", 64'(seen), 64'd0);

    // ROM_LAT=3 good fetch
    fetch3(32'h20, lat, d, enc);
    check("l3_lat", 64'(lat), 64'd4);
    check("l3_en_cycles", 64'(enc), 64'd3);
    check("l3_data", 64'(d), 64'h2322_2120);
    tick();

    // randomized run against a transaction-level model on u0
    prev_a = 32'h0;
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      cat = int'($urandom_range(0, 9));
      if (cat < 5)      a = 32'($urandom_range(0, 511)) << 2;
      else if (cat < 7) a = prev_a + 32'd4;
      else if (cat < 8) a = (32'($urandom_range(0, 511)) << 2) | 32'($urandom_range(1, 3));
      else              a = (32'($urandom_range(0, 511)) << 2) | (32'h1 << $urandom_range(11, 31));
      m_err  = (a % 32'd4 != 0) || (a >= 32'h800);
      m_data = m_err ? 32'h0 : exp_word(a);
`ifdef PU_ROM_PREFETCH_EN
      do_flush = 1'b0;
`else
      do_flush = !m_err && ($urandom_range(0, 7) == 0);
`endif
      check("rnd_ready", 64'(ready0), 64'd1);
      if (do_flush) begin
        req0 = 1'b1; addr0 = a;
        tick();
        req0 = 1'b0; flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        check("rnd_flush_valid", 64'(valid0), 64'd0);
        check("rnd_flush_en", 64'(en0), 64'd0);
        check("rnd_flush_ready", 64'(ready0), 64'd1);
      end else begin
        fetch1(a, lat, d, e, enc, ra);
`ifdef PU_ROM_PREFETCH_EN
        check("rnd_lat_range", 64'(lat >= 1 && lat <= 2), 64'd1);
`else
        check("rnd_lat", 64'(lat), m_err ? 64'd1 : 64'd2);
`endif
        check("rnd_data", 64'(d), 64'(m_data));
        check("rnd_err", 64'(e), 64'(m_err));
        if (m_err) begin
          check("rnd_fault_ready", 64'(ready0), 64'd0);
          tick();
        end else begin
          prev_a = a;
          if ($urandom_range(0, 1) == 0) tick();
        end
      end
    end
    tick();

    // reset in the middle of a ROM_LAT=3 wait
    req3 = 1'b1; addr3 = 32'h30;
    tick();
    req3 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rmid_valid", 64'(valid3), 64'd0);
    check("rmid_ready", 64'(ready3), 64'd0);
    check("rmid_err", 64'(err3), 64'd0);
    check("rmid_en", 64'(en3), 64'd0);
    check("rmid_data", 64'(data3), 64'd0);
    check("rmid_raddr", 64'(raddr3), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid3) seen++;
    end
    check("rmid_no_valid", 64'(seen), 64'd0);
    check("rmid_ready_after", 64'(ready3), 64'd1);

`ifdef PU_ROM_PREFETCH_EN
    // sequential hit from the prefetch buffer, then miss after flush
    fetch1(32'h10, lat, d, e, enc, ra);
    check("pf_first_data", 64'(d), 64'h1312_1110);
    tick();
    repeat (3) tick();
    fetch1(32'h14, lat, d, e, enc, ra);
    check("pf_hit_lat", 64'(lat), 64'd1);
    check("pf_hit_data", 64'(d), 64'h1716_1514);
    tick();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    fetch1(32'h14, lat, d, e, enc, ra);
    check("pf_flushed_lat", 64'(lat), 64'd2);
    check("pf_flushed_data", 64'(d), 64'h1716_1514);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
